dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the CPU load/store path from the control unit and adder; port 1 is the loader/debug port that preloads or inspects data memory.
- Sits between the requesters and the data memory, which has combinational read and a write committed at posedge clk.
- Grants one access per cycle and returns a registered response one cycle later.
- Exposes stall0 so the top level can hold the pc while a CPU access waits.

Parameters:
- ADDR_W, 32, address width of requests and of mem_addr
- DATA_W, 32, data width
- PRIO_MODE, 0, arbitration mode: 0 = round-robin; 1 = fixed priority to port 0 with anti-starvation for port 1
- STARVE_MAX, 4, in PRIO_MODE=1, the number of consecutive blocked cycles after which port 1 is forced through (range 1..255)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request
- req0_we  in  1  port 0 write (1) / read (0)
- req0_addr  in  ADDR_W  port 0 address
- req0_wdata  in  DATA_W  port 0 write data
- req0_ready  out  1  port 0 granted this cycle
- req0_rvalid  out  1  port 0 response valid
- req0_rdata  out  DATA_W  port 0 read data
- stall0  out  1  req0_valid & ~req0_ready
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid, req1_rdata  same as port 0, for port 1
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Handshake:
  - A request transfers in any cycle where reqN_valid & reqN_ready.
  - The requester holds valid/we/addr/wdata stable until ready.
  - readyN is combinational from the current valids and registered arbiter state.
  - At most one ready is high per cycle.
- Memory drive:
  - On a grant, mem_addr/mem_we/mem_wdata are driven combinationally from the winning port.
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - The memory write commits at the same posedge as the grant.
- Response:
  - reqN_rvalid is registered and pulses high for exactly 1 cycle on the cycle after a port-N grant, for reads and writes alike.
  - For a read, reqN_rdata captures mem_rdata at the grant edge and holds until the next port-N read response.
  - For a write, reqN_rdata is unchanged.
  - Latency is 1 cycle from grant to rvalid.
  - Back-to-back grants to one port give rvalid high on consecutive cycles.
- Round-robin (PRIO_MODE=0):
  - Register last_grant (0/1); reset value 1, so port 0 wins the first contention.
  - Both valid: grant to port !last_grant.
  - One valid: grant to it.
  - On every grant, last_grant <= granted port.
- Fixed priority (PRIO_MODE=1):
  - Port 0 wins whenever valid, unless starve_cnt == STARVE_MAX; in that case port 1 wins and port 0 stalls that cycle.
  - starve_cnt: width 8, reset 0.
  - starve_cnt increments (saturating at STARVE_MAX) each cycle req1_valid & ~req1_ready.
  - starve_cnt clears to 0 on a port-1 grant or when req1_valid=0.
  - In PRIO_MODE=0, starve_cnt is held at 0.
- Reset:
  - While rst=1: both ready=0, mem_we=0, and no write is committed.
  - At the reset edge: req0_rvalid=0, req1_rvalid=0, req0_rdata=0, req1_rdata=0, last_grant=1, starve_cnt=0.
  - A grant issued in the cycle before rst rises still completes its memory write. Its rvalid is suppressed if rst is high at the response edge.
- Boundary cases:
  - No valids: idle, no state change except starve_cnt clear.
  - Same address from both ports: serialized in grant order, so a read after a granted write returns the new data.
  - Addresses are passed through unmodified; there is no range check.

Test Plan:
- Reset: hold rst 2 cycles with both valids high -> ready0=ready1=0, mem_we=0, rvalid0/1=0, rdata0/1=0; after release in RR, port 0 granted first.
- Single port write/read: port 0 writes 0xDEADBEEF to addr 5 (cycle 0), then reads addr 5 (cycle 1) -> rvalid0 high in cycles 1 and 2; req0_rdata=0xDEADBEEF in cycle 2.
- RR contention: both ports continuously valid, reads of addr 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1; stall0 high on cycles 1,3,5.
- Fixed priority with starvation, STARVE_MAX=4: both continuously valid -> port 0 granted 4 cycles, port 1 granted on cycle 4, port 0 resumes on cycle 5, and the pattern repeats every 5 cycles.
- Same-address ordering: port 1 writes 0x1234 to addr 9 while port 0 reads addr 9 the cycle after port 1's grant -> req0_rdata=0x1234.
- Reset mid-operation: assert rst in the cycle after a port-1 read grant -> req1_rvalid stays 0, req1_rdata=0; the memory contents written before the reset persist.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data-memory arbiter (round-robin or fixed priority with anti-starvation), 1-cycle registered response
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int PRIO_MODE  = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              stall0,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);
  logic              last_grant;
  logic [7:0]        starve_cnt;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              force1, g0, g1;
  always_comb begin
    force1 = (PRIO_MODE != 0) && req1_valid && (starve_cnt == SMAX);
    g0 = ~rst & req0_valid & ((PRIO_MODE == 0) ? (~req1_valid | last_grant) : ~force1);
    g1 = ~rst & req1_valid & ((PRIO_MODE == 0) ? (~req0_valid | ~last_grant) : (~req0_valid | force1));
    mem_we    = g0 ? req0_we    : g1 ? req1_we    : 1'b0;
    mem_addr  = g0 ? req0_addr  : g1 ? req1_addr  : '0;
    mem_wdata = g0 ? req0_wdata : g1 ? req1_wdata : '0;
  end
  assign req0_ready  = g0;
  assign req1_ready  = g1;
  assign stall0      = req0_valid & ~g0;
  // a response registered just before reset is hidden while reset is held
  assign req0_rvalid = rvalid0_q & ~rst;
  assign req1_rvalid = rvalid1_q & ~rst;
  assign req0_rdata  = rst ? '0 : rdata0_q;
  assign req1_rdata  = rst ? '0 : rdata1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      starve_cnt <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rvalid0_q <= g0;
      rvalid1_q <= g1;
      if (g0 & ~req0_we) rdata0_q <= mem_rdata;
      if (g1 & ~req1_we) rdata1_q <= mem_rdata;
      if (g0 | g1) last_grant <= g1;
      starve_cnt <= (PRIO_MODE == 0 || !req1_valid || g1) ? 8'd0 :
                    (starve_cnt == SMAX) ? starve_cnt : starve_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for a round-robin and a fixed-priority dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        v0 = 0, we0 = 0, v1 = 0, we1 = 0;
  logic [31:0] a0 = 0, d0 = 0, a1 = 0, d1 = 0;
  logic        r0, rv0, st0, r1, rv1, mem_we;
  logic [31:0] rd0, rd1, mem_addr, mem_wdata, mem_rdata;
  logic        fv0 = 0, fv1 = 0;
  logic        f_r0, f_rv0, f_st0, f_r1, f_rv1, f_mwe;
  logic [31:0] f_rd0, f_rd1, f_ma, f_mwd, f_mrd;
  logic [31:0] mem [16];
  logic [15:0] mem_mask = '0;
  logic [31:0] mdl [16];
  logic [15:0] mdl_mask = '0;
  logic [31:0] last0 = 0, last1 = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic        armed = 0;
  int          tests = 0, fails = 0;

  dmem_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req0_ready(r0), .req0_rvalid(rv0), .req0_rdata(rd0), .stall0(st0),
    .req1_valid(v1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .req1_ready(r1), .req1_rvalid(rv1), .req1_rdata(rd1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  dmem_arbiter #(.PRIO_MODE(1), .STARVE_MAX(4)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(fv0), .req0_we(1'b0), .req0_addr(32'd1), .req0_wdata(32'd0),
    .req0_ready(f_r0), .req0_rvalid(f_rv0), .req0_rdata(f_rd0), .stall0(f_st0),
    .req1_valid(fv1), .req1_we(1'b0), .req1_addr(32'd2), .req1_wdata(32'd0),
    .req1_ready(f_r1), .req1_rvalid(f_rv1), .req1_rdata(f_rd1),
    .mem_addr(f_ma), .mem_we(f_mwe), .mem_wdata(f_mwd), .mem_rdata(f_mrd));

  assign f_mrd = f_ma ^ 32'hF000_0000;
  // unwritten words read as 0x100 + index
  assign mem_rdata = mem_mask[mem_addr[3:0]] ? mem[mem_addr[3:0]] : 32'h100 + {28'd0, mem_addr[3:0]};
  always @(posedge clk) if (mem_we) begin
    mem[mem_addr[3:0]] <= mem_wdata;
    mem_mask[mem_addr[3:0]] <= 1'b1;
  end

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mdl_mask[a[3:0]] ? mdl[a[3:0]] : 32'h100 + {28'd0, a[3:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv0, iwe0, input logic [31:0] ia0, id0,
                      input logic iv1, iwe1, input logic [31:0] ia1, id1,
                      input logic e0, e1);
    v0 = iv0; we0 = iwe0; a0 = ia0; d0 = id0;
    v1 = iv1; we1 = iwe1; a1 = ia1; d1 = id1;
    @(negedge clk);
    chk("ready0", r0, e0);
    chk("ready1", r1, e1);
    chk("stall0", st0, iv0 & ~e0);
    chk("mem_we", mem_we, e0 ? iwe0 : e1 ? iwe1 : 1'b0);
    if (e0) begin
      if (!iwe0) last0 = mread(ia0);
      else begin mdl[ia0[3:0]] = id0; mdl_mask[ia0[3:0]] = 1'b1; end
      q0.push_back(last0);
    end
    if (e1) begin
      if (!iwe1) last1 = mread(ia1);
      else begin mdl[ia1[3:0]] = id1; mdl_mask[ia1[3:0]] = 1'b1; end
      q1.push_back(last1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) if (armed) begin
    if (rst) begin
      chk("rst_rvalid0", rv0, 0);
      chk("rst_rvalid1", rv1, 0);
      chk("rst_rdata0", rd0, 0);
      chk("rst_rdata1", rd1, 0);
    end else begin
      if (rv0) begin
        tests++;
        if (q0.size() == 0) begin fails++; $display("FAIL rvalid0: got unexpected pulse, rdata %h", rd0); end
        else begin tests--; chk("rdata0", rd0, q0.pop_front()); end
      end
      if (rv1) begin
        tests++;
        if (q1.size() == 0) begin fails++; $display("FAIL rvalid1: got unexpected pulse, rdata %h", rd1); end
        else begin tests--; chk("rdata1", rd1, q1.pop_front()); end
      end
    end
  end

  initial begin
    v0 = 1; a0 = 1; v1 = 1; a1 = 2;
    @(posedge clk); #1;
    armed = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready0", r0, 0);
      chk("rst_ready1", r1, 0);
      chk("rst_mem_we", mem_we, 0);
      @(posedge clk); #1;
    end
    rst = 0;
    // round-robin contention: 0,1,0,1,0,1
    for (int i = 0; i < 6; i++)
      step(1, 0, 1, 0, 1, 0, 2, 0, (i % 2) == 0, (i % 2) == 1);
    idle();
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
    step(1, 0, 5, 0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("rdata0_hold", rd0, 32'hDEADBEEF);
    // same address: port 1 write then port 0 read
    step(0, 0, 0, 0, 1, 1, 9, 32'h1234, 0, 1);
    step(1, 0, 9, 0, 0, 0, 0, 0, 1, 0);
    idle();
    // reset right after a port-1 read grant
    step(0, 0, 0, 0, 1, 0, 9, 0, 0, 1);
    rst = 1;
    void'(q1.pop_back());
    last0 = 0; last1 = 0;
    @(negedge clk);
    chk("rst_mid_ready1", r1, 0);
    chk("rst_mid_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 0;
    step(1, 0, 5, 0, 1, 0, 9, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 9, 0, 0, 1);
    idle();
    idle();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    // fixed priority with STARVE_MAX=4: port 1 every 5th cycle
    fv0 = 1; fv1 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("fp_ready0", f_r0, (k % 5) != 4);
      chk("fp_ready1", f_r1, (k % 5) == 4);
      chk("fp_stall0", f_st0, (k % 5) == 4);
      @(posedge clk); #1;
    end
    fv0 = 0; fv1 = 0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
